// File: rtl/sprite_anim_engine.sv
// rtl/sprite_anim_engine.sv - scaled multi-frame sprite renderer (optional mirror: SPRITE_HFLIP_EN)
module sprite_anim_engine #(
   parameter int SPR_W      = 54,
   parameter int SPR_H      = 77,
   parameter int SCALE_SH_X = 1,
   parameter int SCALE_SH_Y = 1,
   parameter int FRAMES     = 4,
   parameter int ADDR_W     = 15,
   parameter int IDX_W      = 4,
   parameter int TRANSP_IDX = 0
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [9:0]        SpriteX,
   input  logic [9:0]        SpriteY,
   input  logic              blank,
   input  logic              frame_tick,
   input  logic              anim_start,
   input  logic              anim_loop,
   input  logic [7:0]        hold_frames,
   input  logic              flip,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pix_index,
   output logic              sprite_on,
   output logic              anim_busy,
   output logic              anim_done
);

   localparam int BOX_W    = SPR_W << SCALE_SH_X;
   localparam int BOX_H    = SPR_H << SCALE_SH_Y;
   localparam int FRAME_SZ = SPR_W * SPR_H;
   localparam int FW       = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     frame_q, frame_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              loop_q, loop_d;
   logic              done_q, done_d;
   logic [9:0]        lx_q, lx_d;
   logic [9:0]        ly_q, ly_d;
`ifdef SPRITE_HFLIP_EN
   logic              lflip_q, lflip_d;
`endif

   logic [10:0]       dx, dy, col, row, col_m;
   logic              hit;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] rom_addr_q;
   logic              hit_d1_q, blank_d1_q, hit_d2_q, blank_d2_q;
   logic              sprite_on_d, sprite_on_q;
   logic [IDX_W-1:0]  pix_index_d, pix_index_q;

   // Animation sequencer and frame-synchronous latching of position/mirror
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      loop_d  = loop_q;
      done_d  = 1'b0;
      lx_d    = lx_q;
      ly_d    = ly_q;
`ifdef SPRITE_HFLIP_EN
      lflip_d = lflip_q;
`endif
      if (anim_start) begin
         loop_d = anim_loop;
      end
      if (frame_tick) begin
         lx_d = SpriteX;
         ly_d = SpriteY;
`ifdef SPRITE_HFLIP_EN
         lflip_d = flip;
`endif
         if (pend_q || anim_start) begin
            // a start request overrides whatever the sequencer was doing
            state_d = S_PLAY;
            frame_d = '0;
            cnt_d   = hold_frames;
            pend_d  = 1'b0;
         end else if (state_q == S_PLAY) begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (frame_q != FW'(FRAMES - 1)) begin
               frame_d = frame_q + FW'(1);
               cnt_d   = hold_frames;
            end else if (loop_q) begin
               frame_d = '0;
               cnt_d   = hold_frames;
            end else begin
               state_d = S_HOLD;
               done_d  = 1'b1;
            end
         end
      end else if (anim_start) begin
         pend_d = 1'b1;
      end
   end

   // Sequencer and latched-set registers
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         frame_q <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         loop_q  <= 1'b0;
         done_q  <= 1'b0;
         lx_q    <= '0;
         ly_q    <= '0;
`ifdef SPRITE_HFLIP_EN
         lflip_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         loop_q  <= loop_d;
         done_q  <= done_d;
         lx_q    <= lx_d;
         ly_q    <= ly_d;
`ifdef SPRITE_HFLIP_EN
         lflip_q <= lflip_d;
`endif
      end
   end

   // Box hit test and texel address; negative offsets wrap high and miss the box
   always_comb begin
      dx  = {1'b0, DrawX} - {1'b0, lx_q};
      dy  = {1'b0, DrawY} - {1'b0, ly_q};
      hit = (dx < 11'(BOX_W)) && (dy < 11'(BOX_H));
      col = dx >> SCALE_SH_X;
      row = dy >> SCALE_SH_Y;
`ifdef SPRITE_HFLIP_EN
      col_m = lflip_q ? (11'(SPR_W - 1) - col) : col;
`else
      col_m = col;
`endif
      addr_d = '0;
      if (hit) begin
         addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ)
                + ADDR_W'(row) * ADDR_W'(SPR_W)
                + ADDR_W'(col_m);
      end
   end

   // Final stage: ROM data qualified by delayed hit, blank and transparency
   always_comb begin
      sprite_on_d = hit_d2_q && blank_d2_q && (rom_q != IDX_W'(TRANSP_IDX));
      pix_index_d = sprite_on_d ? rom_q : '0;
   end

   // Three-stage pixel pipeline aligned with the synchronous ROM read
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr_q  <= '0;
         hit_d1_q    <= 1'b0;
         blank_d1_q  <= 1'b0;
         hit_d2_q    <= 1'b0;
         blank_d2_q  <= 1'b0;
         sprite_on_q <= 1'b0;
         pix_index_q <= '0;
      end else begin
         rom_addr_q  <= addr_d;
         hit_d1_q    <= hit;
         blank_d1_q  <= blank;
         hit_d2_q    <= hit_d1_q;
         blank_d2_q  <= blank_d1_q;
         sprite_on_q <= sprite_on_d;
         pix_index_q <= pix_index_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign sprite_on = sprite_on_q;
   assign pix_index = pix_index_q;
   assign anim_busy = (state_q == S_PLAY);
   assign anim_done = done_q;

endmodule

// File: tb/tb_sprite_anim_engine.sv
// tb/tb_sprite_anim_engine.sv - randomized bench for sprite_anim_engine against a behavioural model
module tb_sprite_anim_engine;

   localparam int SPR_W  = 54;
   localparam int SPR_H  = 77;
   localparam int SHX    = 1;
   localparam int SHY    = 1;
   localparam int FRAMES = 4;
   localparam int ADDR_W = 15;
   localparam int IDX_W  = 4;
   localparam int TRANSP = 0;
   localparam int FS     = SPR_W * SPR_H;
   localparam int ROM_N  = FRAMES * FS;
`ifdef SPRITE_HFLIP_EN
   localparam bit FLIP_EN = 1'b1;
`else
   localparam bit FLIP_EN = 1'b0;
`endif

   logic              vga_clk = 1'b0;
   logic              reset_n = 1'b1;
   logic [9:0]        DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
   logic              blank = 1'b0, frame_tick = 1'b0, anim_start = 1'b0;
   logic              anim_loop = 1'b0, flip = 1'b0;
   logic [7:0]        hold_frames = '0;
   logic [ADDR_W-1:0] rom_addr;
   logic [IDX_W-1:0]  rom_q;
   logic [IDX_W-1:0]  pix_index;
   logic              sprite_on, anim_busy, anim_done;

   logic [IDX_W-1:0]  rom [0:ROM_N-1];

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;

   // reference model state
   int mx, my, mflip, mframe, mcnt, mmode, mpend, mloop, mdone;
   int e_on [0:2];
   int e_idx [0:2];

   sprite_anim_engine #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_SH_X(SHX), .SCALE_SH_Y(SHY),
      .FRAMES(FRAMES), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .TRANSP_IDX(TRANSP)
   ) dut (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
      .blank(blank), .frame_tick(frame_tick), .anim_start(anim_start),
      .anim_loop(anim_loop), .hold_frames(hold_frames), .flip(flip),
      .rom_addr(rom_addr), .rom_q(rom_q), .pix_index(pix_index),
      .sprite_on(sprite_on), .anim_busy(anim_busy), .anim_done(anim_done)
   );

   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk) begin
      if (int'(rom_addr) < ROM_N) rom_q <= rom[rom_addr];
      else rom_q <= '0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic void predict(output int a, output int on, output int idx);
      int rx, ry, sx, sy, c, r;
      sx = 1 << SHX;
      sy = 1 << SHY;
      rx = int'(DrawX) - mx;
      ry = int'(DrawY) - my;
      a = 0; on = 0; idx = 0;
      if (rx >= 0 && rx < SPR_W * sx && ry >= 0 && ry < SPR_H * sy) begin
         c = rx / sx;
         r = ry / sy;
         if (FLIP_EN && mflip != 0) c = SPR_W - 1 - c;
         a = mframe * FS + r * SPR_W + c;
         on = (blank && int'(rom[a]) != TRANSP) ? 1 : 0;
         idx = on ? int'(rom[a]) : 0;
      end
   endfunction

   task automatic model_edge();
      mdone = 0;
      if (frame_tick) begin
         mx = int'(SpriteX);
         my = int'(SpriteY);
         mflip = int'(flip);
         if (anim_start) mloop = int'(anim_loop);
         if (mpend != 0 || anim_start) begin
            mmode = 1; mframe = 0; mcnt = int'(hold_frames); mpend = 0;
         end else if (mmode == 1) begin
            if (mcnt > 0) mcnt = mcnt - 1;
            else if (mframe < FRAMES - 1) begin mframe++; mcnt = int'(hold_frames); end
            else if (mloop != 0) begin mframe = 0; mcnt = int'(hold_frames); end
            else begin mmode = 2; mdone = 1; end
         end
      end else if (anim_start) begin
         mpend = 1;
         mloop = int'(anim_loop);
      end
   endtask

   task automatic step();
      int a, on, idx;
      predict(a, on, idx);
      e_on[2] = e_on[1];   e_on[1] = e_on[0];   e_on[0] = on;
      e_idx[2] = e_idx[1]; e_idx[1] = e_idx[0]; e_idx[0] = idx;
      @(posedge vga_clk);
      model_edge();
      #1;
      if (anim_done === 1'b1) done_cnt++;
      check("rom_addr", rom_addr, a);
      check("sprite_on", sprite_on, e_on[2]);
      check("pix_index", pix_index, e_idx[2]);
      check("anim_busy", anim_busy, (mmode == 1));
      check("anim_done", anim_done, mdone);
   endtask

   task automatic apply_reset(input string tag);
      reset_n = 1'b0;
      #1;
      check({tag, "_on"}, sprite_on, 0);
      check({tag, "_idx"}, pix_index, 0);
      check({tag, "_addr"}, rom_addr, 0);
      check({tag, "_busy"}, anim_busy, 0);
      check({tag, "_done"}, anim_done, 0);
      mx = 0; my = 0; mflip = 0; mframe = 0; mcnt = 0; mmode = 0; mpend = 0; mloop = 0; mdone = 0;
      for (int i = 0; i < 3; i++) begin e_on[i] = 0; e_idx[i] = 0; end
      @(posedge vga_clk);
      @(posedge vga_clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic pix_at(input int x, input int y, input bit bl, input int eon, input int eidx, input string tag);
      DrawX = 10'(x); DrawY = 10'(y); blank = bl;
      repeat (3) step();
      check({tag, "_on"}, sprite_on, eon);
      check({tag, "_idx"}, pix_index, eidx);
   endtask

   task automatic addr_at(input int x, input int y, input int ea, input string tag);
      DrawX = 10'(x); DrawY = 10'(y); blank = 1'b1;
      step();
      check(tag, rom_addr, ea);
   endtask

   task automatic probe_frame(input int ef, input string tag);
      DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
      step();
      check(tag, 32'(rom_addr) / FS, ef);
   endtask

   task automatic tick_probe(input int ef, input string tag);
      tick();
      probe_frame(ef, tag);
   endtask

   initial begin
      int seq_once [0:9];
      int seq_loop [0:6];
      seq_once = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
      seq_loop = '{0, 1, 2, 3, 0, 1, 2};
      for (int i = 0; i < ROM_N; i++) rom[i] = IDX_W'($urandom_range(0, 15));
      rom[0] = 4'd5; rom[1] = 4'd9; rom[2] = 4'd0; rom[53] = 4'd7;

      #2;
      apply_reset("reset");

      // directed geometry checks
      SpriteX = 10'd100; SpriteY = 10'd50; flip = 1'b0; blank = 1'b1;
      tick();
      pix_at(100, 50, 1'b1, 1, 5, "tp_first");
      pix_at(99, 50, 1'b1, 0, 0, "tp_x99");
      pix_at(208, 50, 1'b1, 0, 0, "tp_x208");
      addr_at(101, 50, 0, "scale_x101");
      addr_at(102, 50, 1, "scale_x102");
      addr_at(100, 52, 54, "scale_y52");
      pix_at(104, 50, 1'b1, 0, 0, "transp");
      pix_at(100, 50, 1'b0, 0, 0, "blank0");
      if (FLIP_EN) begin
         flip = 1'b1;
         tick();
         addr_at(100, 50, 53, "flip_x0");
         flip = 1'b0;
         tick();
      end

      // play once, hold 1 tick per frame
      anim_loop = 1'b0; hold_frames = 8'd1; anim_start = 1'b1;
      step();
      anim_start = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) tick_probe(seq_once[i], "once_frame");
      check("once_done_cnt", done_cnt, 1);

      // looping, restart mid-sequence, mid-frame position change
      anim_loop = 1'b1; hold_frames = 8'd0; anim_start = 1'b1;
      step();
      anim_start = 1'b0;
      for (int i = 0; i < 7; i++) tick_probe(seq_loop[i], "loop_frame");
      SpriteX = 10'd300;
      probe_frame(2, "midframe_pos");
      SpriteX = 10'd100;
      anim_start = 1'b1;
      step();
      anim_start = 1'b0;
      tick_probe(0, "restart_frame");
      tick_probe(1, "restart_next");

      // start coincident with frame_tick
      anim_loop = 1'b0; hold_frames = 8'd0; done_cnt = 0;
      anim_start = 1'b1;
      tick();
      anim_start = 1'b0;
      probe_frame(0, "coinc_frame");
      tick_probe(1, "coinc_frame");
      tick_probe(2, "coinc_frame");
      tick_probe(3, "coinc_frame");
      tick_probe(3, "coinc_hold");
      tick_probe(3, "coinc_hold");
      check("coinc_done_cnt", done_cnt, 1);

      // randomized traffic with a mid-line asynchronous reset
      for (int n = 0; n < 900; n++) begin
         frame_tick  = ($urandom_range(0, 19) == 0);
         anim_start  = ($urandom_range(0, 29) == 0);
         anim_loop   = 1'($urandom_range(0, 1));
         hold_frames = 8'($urandom_range(0, 2));
         if ($urandom_range(0, 49) == 0) flip = ~flip;
         if ($urandom_range(0, 39) == 0) begin
            SpriteX = 10'($urandom_range(0, 1023));
            SpriteY = 10'($urandom_range(0, 1023));
         end
         if ($urandom_range(0, 3) != 0) begin
            DrawX = 10'(mx + int'($urandom_range(0, 230)) - 5);
            DrawY = 10'(my + int'($urandom_range(0, 165)) - 5);
         end else begin
            DrawX = 10'($urandom_range(0, 1023));
            DrawY = 10'($urandom_range(0, 1023));
         end
         blank = ($urandom_range(0, 4) != 0);
         step();
         if (n == 450) begin
            #2;
            apply_reset("rst_async");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
